and_gate_bist: RTL and testbench

AND_GATE_BIST -- requirements
Module: and_gate_bist

---
 rtl/and_gate_bist_if.sv | 38 +++
 rtl/and_gate_bist.sv | 122 ++++++++++++
 tb/tb_and_gate_bist.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/and_gate_bist_if.sv
// rtl/and_gate_bist_if.sv - control, stimulus and result signals between the AND-gate BIST and its environment
interface and_gate_bist_if;
    logic       start;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] y;
    logic       busy;
    logic       done;
    logic [2:0] fail;
    logic [1:0] gate_idx;
    logic [1:0] vec_idx;

    // The BIST drives the gate inputs and its status; it receives start and the gate outputs.
    modport master (
        input  start,
        input  y,
        output a,
        output b,
        output busy,
        output done,
        output fail,
        output gate_idx,
        output vec_idx
    );

    // The environment (gates under test plus controller) sees the mirror image.
    modport slave (
        output start,
        output y,
        input  a,
        input  b,
        input  busy,
        input  done,
        input  fail,
        input  gate_idx,
        input  vec_idx
    );
endinterface

// File: rtl/and_gate_bist.sv
// rtl/and_gate_bist.sv - exhaustive 4-vector self-test of three 2-input AND gates
module and_gate_bist #(
    // Cycles each vector is held before the gate output is sampled, 1..15.
    parameter int unsigned SETTLE = 2
) (
    input  logic          clk,
    input  logic          rst,
    and_gate_bist_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // The down-counter is loaded with SETTLE-1 so DRIVE spans exactly SETTLE cycles.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] gate_q, gate_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] fail_q, fail_d;

    // Vector order v0..v3 is (1,1), (0,1), (1,0), (0,0): each operand is the
    // inverse of one index bit, so the expected AND output is high only for v0.
    logic vec_a;
    logic vec_b;
    logic exp_y;
    logic active;
    logic [2:0] gate_sel;

    assign vec_a    = ~vec_q[0];
    assign vec_b    = ~vec_q[1];
    assign exp_y    = vec_a & vec_b;
    assign active   = (state_q == DRIVE) || (state_q == CHECK);
    assign gate_sel = 3'b001 << gate_q;

    // Only the gate under test sees the vector; every other A/B bit stays low.
    assign bus.a        = (active && vec_a) ? gate_sel : 3'b000;
    assign bus.b        = (active && vec_b) ? gate_sel : 3'b000;
    assign bus.busy     = active;
    assign bus.done     = (state_q == FINISH);
    assign bus.fail     = fail_q;
    assign bus.gate_idx = gate_q;
    assign bus.vec_idx  = vec_q;

    // Next-state and datapath update: sequencing of vectors and gates, sticky fail capture.
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        case (state_q)
            IDLE, FINISH: begin
                if (bus.start) begin
                    state_d = DRIVE;
                    gate_d  = 2'd0;
                    vec_d   = 2'd0;
                    cnt_d   = SETTLE_LOAD;
                    fail_d  = 3'b000;
                end
            end
            DRIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CHECK: begin
                // Only the output of the gate under test is ever compared.
                if (bus.y[gate_q] != exp_y) begin
                    fail_d[gate_q] = 1'b1;
                end
                cnt_d = SETTLE_LOAD;
                if (vec_q != 2'd3) begin
                    state_d = DRIVE;
                    vec_d   = vec_q + 2'd1;
                end else if (gate_q != 2'd2) begin
                    state_d = DRIVE;
                    gate_d  = gate_q + 2'd1;
                    vec_d   = 2'd0;
                end else begin
                    // Run complete; indices return to 0 so FINISH looks idle apart from DONE/FAIL.
                    state_d = FINISH;
                    gate_d  = 2'd0;
                    vec_d   = 2'd0;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                gate_d  = 2'd0;
                vec_d   = 2'd0;
                cnt_d   = 4'd0;
                fail_d  = 3'b000;
            end
        endcase
    end

    // State register; reset wins over everything, including a simultaneous start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gate_q  <= 2'd0;
            vec_q   <= 2'd0;
            cnt_q   <= 4'd0;
            fail_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
        end
    end

endmodule

// File: tb/tb_and_gate_bist.sv
// tb/tb_and_gate_bist.sv - self-checking bench for and_gate_bist with faulty-gate models
module tb_and_gate_bist;

    logic clk = 1'b0;
    logic rst;
    logic start2;
    logic start4;

    always #5 clk = ~clk;

    and_gate_bist_if bus2 ();
    and_gate_bist_if bus4 ();

    and_gate_bist #(.SETTLE(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.master)
    );

    and_gate_bist #(.SETTLE(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.master)
    );

    // Fault per gate: 0 ideal (optionally delayed by fdel cycles), 1 stuck-at-0, 2 stuck-at-1.
    int ftype [3];
    int fdel  [3];

    logic [2:0] hist2 [8];
    logic [2:0] hist4 [8];
    logic [2:0] y2;
    logic [2:0] y4;

    assign bus2.start = start2;
    assign bus4.start = start4;
    assign bus2.y     = y2;
    assign bus4.y     = y4;

    // Delay lines of the ideal AND results, one per DUT.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                hist2[k] <= 3'b000;
                hist4[k] <= 3'b000;
            end
        end else begin
            hist2[0] <= bus2.a & bus2.b;
            hist4[0] <= bus4.a & bus4.b;
            for (int k = 1; k < 8; k++) begin
                hist2[k] <= hist2[k-1];
                hist4[k] <= hist4[k-1];
            end
        end
    end

    // Gate models under test.
    always_comb begin
        y2 = 3'b000;
        y4 = 3'b000;
        for (int g = 0; g < 3; g++) begin
            if (ftype[g] == 1) begin
                y2[g] = 1'b0;
                y4[g] = 1'b0;
            end else if (ftype[g] == 2) begin
                y2[g] = 1'b1;
                y4[g] = 1'b1;
            end else if (fdel[g] == 0) begin
                y2[g] = bus2.a[g] & bus2.b[g];
                y4[g] = bus4.a[g] & bus4.b[g];
            end else begin
                y2[g] = hist2[fdel[g]-1][g];
                y4[g] = hist4[fdel[g]-1][g];
            end
        end
    end

    bit         sel4;
    logic       o_busy;
    logic       o_done;
    logic [2:0] o_a;
    logic [2:0] o_b;
    logic [2:0] o_fail;
    logic [1:0] o_gi;
    logic [1:0] o_vi;

    always_comb begin
        o_busy = sel4 ? bus4.busy     : bus2.busy;
        o_done = sel4 ? bus4.done     : bus2.done;
        o_a    = sel4 ? bus4.a        : bus2.a;
        o_b    = sel4 ? bus4.b        : bus2.b;
        o_fail = sel4 ? bus4.fail     : bus2.fail;
        o_gi   = sel4 ? bus4.gate_idx : bus2.gate_idx;
        o_vi   = sel4 ? bus4.vec_idx  : bus2.vec_idx;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel4) start4 = v;
        else      start2 = v;
    endtask

    // Reference: lay the whole run out as a timeline of slots of (s+1) cycles,
    // slot k = gate k/4, vector k%4.  A gate delayed by d cycles shows at the
    // sampling cycle whatever its inputs were d cycles earlier.
    function automatic logic [2:0] exp_fail(input int s);
        logic [2:0] f;
        int t, tt, seg;
        logic want, obs;
        f = 3'b000;
        for (int g = 0; g < 3; g++) begin
            for (int v = 0; v < 4; v++) begin
                t    = (g*4 + v)*(s+1) + s;
                want = (v == 0);
                if (ftype[g] == 1)      obs = 1'b0;
                else if (ftype[g] == 2) obs = 1'b1;
                else begin
                    tt = t - fdel[g];
                    if (tt < 0) obs = 1'b0;
                    else begin
                        seg = tt / (s+1);
                        obs = (seg / 4 == g) && (seg % 4 == 0);
                    end
                end
                if (obs != want) f[g] = 1'b1;
            end
        end
        return f;
    endfunction

    task automatic run(input bit armed, input bit hold, input int abort_at, input int repulse_at);
        int s, n, seg, g, v;
        logic [2:0] ea, eb, ef;
        s = sel4 ? 4 : 2;
        n = 12*(s+1);
        if (!armed) @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            if (t == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("rst_abort", {o_busy, o_done, o_fail, o_a, o_b, o_gi, o_vi}, 0);
                rst = 1'b0;
                return;
            end
            if (t == 0) check("fail_clr", o_fail, 0);
            seg = t / (s+1);
            g   = seg / 4;
            v   = seg % 4;
            ea  = (v == 0 || v == 2) ? 3'(1 << g) : 3'b000;
            eb  = (v < 2) ? 3'(1 << g) : 3'b000;
            check("busy", {o_busy, o_done}, 2'b10);
            check("vector", {o_a, o_b, o_gi, o_vi}, {ea, eb, 2'(g), 2'(v)});
            if (!hold && t == 0) set_start(1'b0);
            if (t == repulse_at) set_start(1'b1);
            if (!hold && t == repulse_at + 1) set_start(1'b0);
        end
        @(negedge clk);
        ef = exp_fail(s);
        check("finish", {o_busy, o_done, o_a, o_b, o_gi, o_vi}, {2'b01, 10'b0});
        check("fail", o_fail, ef);
        set_start(1'b0);
        repeat (2) @(negedge clk);
        check("hold", {o_busy, o_done, o_fail}, {2'b01, ef});
    endtask

    task automatic clear_faults();
        for (int g = 0; g < 3; g++) begin
            ftype[g] = 0;
            fdel[g]  = 0;
        end
    endtask

    initial begin
        int r, n;
        rst    = 1'b1;
        start2 = 1'b0;
        start4 = 1'b0;
        sel4   = 1'b0;
        clear_faults();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset2", {bus2.busy, bus2.done, bus2.fail, bus2.a, bus2.b, bus2.gate_idx, bus2.vec_idx}, 0);
        check("reset4", {bus4.busy, bus4.done, bus4.fail, bus4.a, bus4.b, bus4.gate_idx, bus4.vec_idx}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle2", {bus2.busy, bus2.done, bus2.fail, bus2.a, bus2.b}, 0);
        check("idle4", {bus4.busy, bus4.done, bus4.fail, bus4.a, bus4.b}, 0);

        // Ideal gates, single-cycle start pulse.
        run(1'b0, 1'b0, -1, -1);

        // Gate 1 stuck-at-1.
        ftype[1] = 2;
        run(1'b0, 1'b0, -1, -1);

        // Restart from FINISH after a failing run, with a mid-run start re-pulse.
        clear_faults();
        run(1'b0, 1'b0, -1, 14);

        // Gate 2 delayed by 3 cycles against both settle times.
        fdel[2] = 3;
        run(1'b0, 1'b0, -1, -1);
        sel4 = 1'b1;
        run(1'b0, 1'b0, -1, -1);

        // Reset during busy cycle 10 with start held, then the immediate re-run.
        clear_faults();
        sel4 = 1'b0;
        run(1'b0, 1'b1, 9, -1);
        check("idle_other", {bus4.busy, bus4.done, bus4.fail}, 0);
        run(1'b1, 1'b1, -1, -1);

        // Randomized fault mixes, instances, start styles.
        for (int it = 0; it < 12; it++) begin
            sel4 = 1'($urandom_range(0, 1));
            for (int g = 0; g < 3; g++) begin
                r = int'($urandom_range(0, 5));
                ftype[g] = (r == 4) ? 1 : (r == 5) ? 2 : 0;
                fdel[g]  = int'($urandom_range(0, 5));
            end
            n = sel4 ? 60 : 36;
            r = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, n - 4)) : -1;
            run(1'b0, 1'($urandom_range(0, 1)), -1, r);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
